seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one 3-bit seven-segment decoder across NUM_DIGITS display digits. It holds a frame buffer of per-digit 3-bit codes and steps a one-hot digit select at a programmable refresh rate. It drives the decoder's data input with the code for the selected digit. New frame contents are accepted through a valid/ready handshake and applied only on frame boundaries, so a digit never changes mid-frame.

---
 rtl/seg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller that shares one 3-bit seven-segment
// decoder across NUM_DIGITS digits. A frame buffer of per-digit codes is
// scanned with a one-hot digit select. Each digit stays selected for
// REFRESH_DIV cycles. New frame data is taken through a valid/ready handshake
// and is only made visible on a frame boundary, so a digit never changes
// part-way through a frame.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   enable_i       1 = scan running, 0 = display off
//   load_valid_i   load request
//   load_ready_o   high while no load is pending
//   load_data_i    digit codes, digit k at [3k+2:3k]
//   blank_i        per-digit blank, forces that digit's select low
//   digit_code_o   code for the current digit (decoder data input)
//   digit_sel_o    one-hot active-high digit enable
//   frame_done_o   one-cycle pulse on the last cycle of each frame
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | display off, counters held at 0, a pending load commits at once
// SCAN  | stepping through the digits, a pending load commits at frame wrap

module seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic                      load_valid_i,
   output logic                      load_ready_o,
   input  logic [3*NUM_DIGITS-1:0]   load_data_i,
   input  logic [NUM_DIGITS-1:0]     blank_i,
   output logic [2:0]                digit_code_o,
   output logic [NUM_DIGITS-1:0]     digit_sel_o,
   output logic                      frame_done_o
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [DIV_W-1:0]          div_q, div_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [3*NUM_DIGITS-1:0]   active_q, active_d;
   logic [3*NUM_DIGITS-1:0]   pending_q, pending_d;
   logic                      pending_valid_q, pending_valid_d;

   logic div_last;
   logic idx_last;

   assign div_last = (div_q == DIV_W'(REFRESH_DIV - 1));
   assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

   always_comb begin
      state_d         = state_q;
      div_d           = div_q;
      idx_d           = idx_q;
      active_d        = active_q;
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;

      // Acceptance needs an empty pending slot and a commit needs a full one,
      // so the two never fight over pending_valid in the same cycle.
      if (load_valid_i && !pending_valid_q) begin
         pending_d       = load_data_i;
         pending_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            idx_d = '0;
            if (pending_valid_q) begin
               active_d        = pending_q;
               pending_valid_d = 1'b0;
            end
            if (enable_i) begin
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (!enable_i) begin
               // Any pending load survives and commits once back in IDLE.
               state_d = ST_IDLE;
               div_d   = '0;
               idx_d   = '0;
            end else if (div_last) begin
               div_d = '0;
               if (idx_last) begin
                  idx_d = '0;
                  if (pending_valid_q) begin
                     active_d        = pending_q;
                     pending_valid_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         div_q           <= '0;
         idx_q           <= '0;
         active_q        <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         div_q           <= div_d;
         idx_q           <= idx_d;
         active_q        <= active_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
      end
   end

   // Display outputs depend only on registered state and blank_i.
   assign load_ready_o = !pending_valid_q;
   assign frame_done_o = (state_q == ST_SCAN) && div_last && idx_last;

   always_comb begin
      digit_sel_o  = '0;
      digit_code_o = '0;
      if (state_q == ST_SCAN) begin
         digit_code_o = active_q[3*idx_q +: 3];
         digit_sel_o  = (NUM_DIGITS'(1) << idx_q) & ~blank_i;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        lv;
   logic        lr;
   logic [11:0] ldata;
   logic [3:0]  blank;
   logic [2:0]  code;
   logic [3:0]  sel;
   logic        fd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (en),
      .load_valid_i (lv),
      .load_ready_o (lr),
      .load_data_i  (ldata),
      .blank_i      (blank),
      .digit_code_o (code),
      .digit_sel_o  (sel),
      .frame_done_o (fd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; sample 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_off(input string tag, input logic rdy_e);
      chk({tag, "_sel"},   32'(sel),  32'h0);
      chk({tag, "_code"},  32'(code), 32'h0);
      chk({tag, "_fd"},    32'(fd),   32'h0);
      chk({tag, "_ready"}, 32'(lr),   32'(rdy_e));
   endtask

   task automatic chk_slot(input string tag, input int d, input int c,
                           input logic [2:0] code_e, input logic [3:0] blank_e,
                           input logic rdy_e);
      logic [3:0] sel_e;
      logic       fd_e;
      string      t;
      sel_e = (4'b0001 << d) & ~blank_e;
      fd_e  = (d == 3) && (c == 3);
      t = $sformatf("%s_d%0d_c%0d", tag, d, c);
      chk({t, "_sel"},   32'(sel),  32'(sel_e));
      chk({t, "_code"},  32'(code), 32'(code_e));
      chk({t, "_fd"},    32'(fd),   32'(fd_e));
      chk({t, "_ready"}, 32'(lr),   32'(rdy_e));
   endtask

   logic [2:0] codes_a [4];
   logic       rdy;

   initial begin
      codes_a[0] = 3'd5; codes_a[1] = 3'd6; codes_a[2] = 3'd7; codes_a[3] = 3'd1;

      // 1. reset with enable and load_valid asserted
      rst = 1'b1; en = 1'b1; lv = 1'b1; ldata = 12'hABC; blank = 4'b0000;
      step();
      chk_off("rst1", 1'b1);
      step();
      chk_off("rst2", 1'b1);
      rst = 1'b0; en = 1'b0; lv = 1'b0;

      // 2. load in IDLE, then scan two frames
      lv = 1'b1; ldata = 12'h3F5;
      step();
      lv = 1'b0;
      chk_off("idle_acc", 1'b0);
      step();
      chk_off("idle_commit", 1'b1);
      en = 1'b1;
      step();
      for (int f = 0; f < 2; f++) begin
         for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
               chk_slot($sformatf("scan_f%0d", f), d, c, codes_a[d], 4'b0000, 1'b1);
               step();
            end
         end
      end

      // 3. mid-frame load of all zeros while digit 1 is shown
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            rdy = (d == 0) || (d == 1 && c <= 1);
            chk_slot("midload", d, c, codes_a[d], 4'b0000, rdy);
            if (d == 1 && c == 1) begin
               lv = 1'b1; ldata = 12'h000;
            end else begin
               lv = 1'b0;
            end
            step();
         end
      end

      // 4. new zero frame, digit 2 blanked
      blank = 4'b0100;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            chk_slot("blank", d, c, 3'd0, 4'b0100, 1'b1);
            step();
         end
      end
      blank = 4'b0000;

      // reload 5,6,7,1 at start of a frame; shown from the following frame
      lv = 1'b1; ldata = 12'h3F5;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            chk_slot("reload", d, c, 3'd0, 4'b0000, (d == 0 && c == 0));
            step();
            lv = 1'b0;
         end
      end

      // 5. disable during digit 2, then re-enable
      for (int d = 0; d < 3; d++) begin
         for (int c = 0; c < 4; c++) begin
            if (d < 2 || c < 2) begin
               chk_slot("predis", d, c, codes_a[d], 4'b0000, 1'b1);
               step();
            end
         end
      end
      en = 1'b0;
      step();
      chk_off("dis1", 1'b1);
      step();
      chk_off("dis2", 1'b1);
      en = 1'b1;
      step();
      for (int c = 0; c < 4; c++) begin
         chk_slot("reen", 0, c, 3'd5, 4'b0000, 1'b1);
         step();
      end
      chk_slot("reen", 1, 0, 3'd6, 4'b0000, 1'b1);

      // 6. reset mid-scan with a pending load
      lv = 1'b1; ldata = 12'hFFF;
      step();
      lv = 1'b0;
      chk_slot("pend", 1, 1, 3'd6, 4'b0000, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_off("rst_mid", 1'b1);
      step();
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            chk_slot("postrst", d, c, 3'd0, 4'b0000, 1'b1);
            step();
         end
      end
      chk_slot("postrst_wrap", 0, 0, 3'd0, 4'b0000, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
